// File: rtl/sync_ft_fifo_pkg.sv
// Shared FIFO constants for the fall-through FIFO and its APB register front-end.
// Status word layout is defined here so both sides agree on bit positions.
package sync_ft_fifo_pkg;

    localparam int FIFO_WIDTH     = 8;
    localparam int FIFO_AW        = 8;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_LEVEL_LSB = 8;
    localparam int STAT_LEVEL_W   = FIFO_AW + 1;

    // Builds the status register image read back through the APB front-end.
    function automatic logic [31:0] pack_status(input logic empty,
                                                input logic full,
                                                input logic [STAT_LEVEL_W-1:0] level);
        logic [31:0] s;
        s = '0;
        s[STAT_EMPTY_BIT] = empty;
        s[STAT_FULL_BIT]  = full;
        s[STAT_LEVEL_LSB +: STAT_LEVEL_W] = level;
        return s;
    endfunction

endpackage

// File: rtl/sync_ft_fifo_if.sv
// Command/status bundle between the APB FIFO front-end (master) and the FIFO (slave).
interface sync_ft_fifo_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
);
    logic             enable;
    logic             ff_write;
    logic [WIDTH-1:0] ff_wdata;
    logic             ff_read;
    logic             ff_clear;
    logic [WIDTH-1:0] ff_rdata;
    logic             ff_full;
    logic             ff_empty;
    logic [AW:0]      ff_level;
    logic             ff_overflow;
    logic             ff_underflow;

    modport master (
        output enable, ff_write, ff_wdata, ff_read, ff_clear,
        input  ff_rdata, ff_full, ff_empty, ff_level, ff_overflow, ff_underflow
    );

    modport slave (
        input  enable, ff_write, ff_wdata, ff_read, ff_clear,
        output ff_rdata, ff_full, ff_empty, ff_level, ff_overflow, ff_underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: register array with a synchronous write port and an asynchronous read port.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_ft_fifo.sv
// Synchronous fall-through FIFO: head entry is always visible on ff_rdata.
// Pointers carry a wrap bit so full and empty are told apart without extra state.
module sync_ft_fifo
    import sync_ft_fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int AW    = FIFO_AW
) (
    input  logic          pclk,
    input  logic          reset_n,
    sync_ft_fifo_if.slave ff
);
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
    logic [AW:0]      level;
    logic             full_q, empty_q, ovf_q, unf_q;
    logic             push, pop, mem_we;
    logic [WIDTH-1:0] mem_rdata;

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign pop        = ff.ff_read & ~empty_q;
    assign push       = ff.ff_write & (~full_q | ff.ff_read);
    assign wr_ptr_nxt = push ? wr_ptr + (AW+1)'(1) : wr_ptr;
    assign rd_ptr_nxt = pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
    assign mem_we     = ff.enable & ~ff.ff_clear & push;

    fifo_mem #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (pclk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (ff.ff_wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (ff.enable) begin
            if (ff.ff_clear) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level   <= '0;
                full_q  <= 1'b0;
                empty_q <= 1'b1;
                ovf_q   <= 1'b0;
                unf_q   <= 1'b0;
            end else begin
                wr_ptr  <= wr_ptr_nxt;
                rd_ptr  <= rd_ptr_nxt;
                full_q  <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                           (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
                empty_q <= (wr_ptr_nxt == rd_ptr_nxt);
                case ({push, pop})
                    2'b10:   level <= level + (AW+1)'(1);
                    2'b01:   level <= level - (AW+1)'(1);
                    default: level <= level;
                endcase
                if (ff.ff_write && full_q && !ff.ff_read) begin
                    ovf_q <= 1'b1;
                end
                if (ff.ff_read && empty_q) begin
                    unf_q <= 1'b1;
                end
            end
        end
    end

    assign ff.ff_rdata     = empty_q ? '0 : mem_rdata;
    assign ff.ff_full      = full_q;
    assign ff.ff_empty     = empty_q;
    assign ff.ff_level     = level;
    assign ff.ff_overflow  = ovf_q;
    assign ff.ff_underflow = unf_q;
endmodule

// File: tb/tb_sync_ft_fifo.sv
// Bench for sync_ft_fifo: directed scenarios plus random traffic against a queue model.
module tb_sync_ft_fifo;
    localparam int W     = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 2**AW;

    logic pclk    = 1'b0;
    logic reset_n = 1'b0;
    always #5 pclk = ~pclk;

    sync_ft_fifo_if #(.WIDTH(W), .AW(AW)) bus ();

    sync_ft_fifo #(.WIDTH(W), .AW(AW)) dut (
        .pclk    (pclk),
        .reset_n (reset_n),
        .ff      (bus)
    );

    int         tests = 0;
    int         fails = 0;
    logic [W-1:0] q[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string where);
        chk({where, ":rdata"}, 32'(bus.ff_rdata), (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk({where, ":level"}, 32'(bus.ff_level), 32'(q.size()));
        chk({where, ":full"},  32'(bus.ff_full),  32'(q.size() == DEPTH));
        chk({where, ":empty"}, 32'(bus.ff_empty), 32'(q.size() == 0));
        chk({where, ":ovf"},   32'(bus.ff_overflow),  32'(m_ovf));
        chk({where, ":unf"},   32'(bus.ff_underflow), 32'(m_unf));
    endtask

    // Queue model: a pop takes the oldest word, a push appends; a full queue
    // accepts a push only if a pop frees room in the same cycle.
    task automatic model(input bit en, input bit w, input bit r, input bit c,
                         input logic [W-1:0] d);
        bit was_empty;
        bit was_full;
        if (!en) return;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        if (r && was_empty)        m_unf = 1'b1;
        if (w && was_full && !r)   m_ovf = 1'b1;
        if (r && !was_empty)       void'(q.pop_front());
        if (w && (!was_full || r)) q.push_back(d);
    endtask

    task automatic step(input bit en, input bit w, input bit r, input bit c,
                        input logic [W-1:0] d, input string where);
        @(negedge pclk);
        bus.enable   = en;
        bus.ff_write = w;
        bus.ff_read  = r;
        bus.ff_clear = c;
        bus.ff_wdata = d;
        @(posedge pclk);
        model(en, w, r, c, d);
        #1;
        chk_all(where);
    endtask

    initial begin
        logic [W-1:0] d;
        bit en, w, r, c;

        bus.enable   = 1'b1;
        bus.ff_write = 1'b0;
        bus.ff_read  = 1'b0;
        bus.ff_clear = 1'b0;
        bus.ff_wdata = '0;

        // Reset state
        #12;
        chk_all("reset");
        @(negedge pclk);
        reset_n = 1'b1;

        // Two pushes, two pops
        step(1, 1, 0, 0, 8'hA5, "push_a5");
        chk("t2_head_a5", 32'(bus.ff_rdata), 32'h0000_00A5);
        step(1, 1, 0, 0, 8'h3C, "push_3c");
        chk("t2_level2", 32'(bus.ff_level), 32'd2);
        step(1, 0, 1, 0, 8'h00, "pop1");
        chk("t2_head_3c", 32'(bus.ff_rdata), 32'h0000_003C);
        step(1, 0, 1, 0, 8'h00, "pop2");
        chk("t2_empty_rdata", 32'(bus.ff_rdata), 32'd0);

        // Fill, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, 8'(i), "fill");
        chk("t3_full", 32'(bus.ff_full), 32'd1);
        chk("t3_level256", 32'(bus.ff_level), 32'd256);
        step(1, 1, 0, 0, 8'hEE, "overflow");
        chk("t3_ovf", 32'(bus.ff_overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_order", 32'(bus.ff_rdata), 32'(i));
            step(1, 0, 1, 0, 8'h00, "drain");
        end
        step(1, 0, 0, 1, 8'h00, "clear3");

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, 8'($urandom), "fill4");
        step(1, 1, 1, 0, 8'h77, "full_rw");
        chk("t4_level", 32'(bus.ff_level), 32'd256);
        chk("t4_no_ovf", 32'(bus.ff_overflow), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 1, 0, 8'h00, "drain4");
        chk("t4_last_77", 32'(bus.ff_rdata), 32'h0000_0077);
        step(1, 0, 1, 0, 8'h00, "drain4_last");

        // Empty with simultaneous push and pop, then clear
        step(1, 1, 1, 0, 8'h11, "empty_rw");
        chk("t5_level1", 32'(bus.ff_level), 32'd1);
        chk("t5_rdata11", 32'(bus.ff_rdata), 32'h0000_0011);
        chk("t5_unf", 32'(bus.ff_underflow), 32'd1);
        step(1, 0, 0, 1, 8'h00, "clear5");
        chk("t5_unf_cleared", 32'(bus.ff_underflow), 32'd0);

        // Enable low freezes state; then wrap pointers with push/pop pairs
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 8'($urandom), "pre6");
        for (int i = 0; i < 20; i++)
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), "disabled");
        for (int i = 0; i < 300; i++) step(1, 1, 1, 0, 8'($urandom), "wrap");
        chk("t6_level5", 32'(bus.ff_level), 32'd5);

        // Random traffic: write-heavy then read-heavy phases
        for (int i = 0; i < 1200; i++) begin
            d  = 8'($urandom);
            en = ($urandom_range(7) != 0);
            c  = ($urandom_range(199) == 0);
            if (i < 600) begin
                w = ($urandom_range(3) != 0);
                r = ($urandom_range(3) == 0);
            end else begin
                w = ($urandom_range(3) == 0);
                r = ($urandom_range(3) != 0);
            end
            step(en, w, r, c, d, "random");
        end

        // Asynchronous reset in the middle of operation
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 8'($urandom), "pre_rst");
        step(1, 0, 0, 0, 8'h00, "idle");
        @(negedge pclk);
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk_all("async_rst");
        @(negedge pclk);
        reset_n = 1'b1;
        step(1, 1, 0, 0, 8'h5A, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
